// File: rtl/hazard_detection_unit_pkg.sv
// Shared types and helpers for the decode-side hazard detection unit.
// Defines the shadow-slot bundle, the x0 constant and the rs match test.
package hazard_detection_unit_pkg;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wr_en;
    logic       is_load;
  } hz_slot_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // True when an in-flight slot produces the register ID wants to read.
  function automatic logic slot_match(
    input hz_slot_t   slot,
    input logic [4:0] rs,
    input logic       used
  );
    return slot.valid && slot.wr_en &&
           (slot.rd != REG_ZERO) &&
           (slot.rd == rs) && used;
  endfunction

endpackage

// File: rtl/hz_sat_counter.sv
// Saturating event counter: counts up on inc, sticks at all-ones.
// Ports: clk, rst (async active-high), inc, cnt[W-1:0].
module hz_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/hazard_detection_unit.sv
// Decode-side hazard unit: stalls on uncovered RAW hazards, flushes on redirect.
// Ports: clk_i/rst_i, ID operand info, ex_redirect_i; stall/flush controls, counters.
module hazard_detection_unit
  import hazard_detection_unit_pkg::*;
#(
  parameter bit FWD_EN    = 1'b1,
  parameter bit RF_BYPASS = 1'b1,
  parameter int CNT_W     = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [4:0]       id_rd_addr_i,
  input  logic             id_rd_wr_en_i,
  input  logic             id_is_load_i,
  input  logic             ex_redirect_i,
  output logic             pc_stall_o,
  output logic             if_id_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  hz_slot_t ex_q;
  hz_slot_t mem_q;
  hz_slot_t wb_q;
  hz_slot_t ex_d;

  logic ex_hit;
  logic mem_hit;
  logic wb_hit;
  logic stall;
  logic redirect;
  logic stall_only;

  always_comb begin
    ex_hit  = slot_match(ex_q, id_rs1_addr_i, id_rs1_used_i) ||
              slot_match(ex_q, id_rs2_addr_i, id_rs2_used_i);
    mem_hit = slot_match(mem_q, id_rs1_addr_i, id_rs1_used_i) ||
              slot_match(mem_q, id_rs2_addr_i, id_rs2_used_i);
    wb_hit  = slot_match(wb_q, id_rs1_addr_i, id_rs1_used_i) ||
              slot_match(wb_q, id_rs2_addr_i, id_rs2_used_i);
    stall   = 1'b0;
    if (FWD_EN) begin
      // Only a load in EX is too late for the forwarding network.
      stall = id_valid_i && ex_q.is_load && ex_hit;
    end else begin
      stall = id_valid_i &&
              (ex_hit || mem_hit || (!RF_BYPASS && wb_hit));
    end
  end

  assign redirect   = ex_redirect_i;
  assign stall_only = stall && !redirect;

  assign pc_stall_o    = stall_only;
  assign if_id_stall_o = stall_only;
  assign if_id_flush_o = redirect;
  assign id_ex_flush_o = redirect || stall;

  always_comb begin
    ex_d = '0;
    if (id_valid_i && !stall && !redirect) begin
      ex_d.valid   = 1'b1;
      ex_d.rd      = id_rd_addr_i;
      ex_d.wr_en   = id_rd_wr_en_i;
      ex_d.is_load = id_is_load_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  hz_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk_i),
    .rst (rst_i),
    .inc (stall_only),
    .cnt (stall_cnt_o)
  );

  hz_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk_i),
    .rst (rst_i),
    .inc (redirect),
    .cnt (flush_cnt_o)
  );

endmodule
